// File: rtl/regime_decode_arbiter.sv
// Round-robin share of one posit regime decoder between N_REQ requesters; result is registered with requester id.
// Result one cycle after acceptance; a held result stalls the operand stage, which then drops req_ready.
module seed_lookup #(
   parameter int BITS = 32
) (
   input  logic [BITS-1:0] data,
   output logic [BITS-1:0] seed,
   output logic [BITS-1:0] shifted_data
);
   localparam int CW = $clog2(BITS) + 1;

   logic          s;
   logic          done;
   logic [CW-1:0] run;
   logic [CW:0]   shamt;

   assign s = data[BITS-2];

   // run = number of bits equal to s, counted down from BITS-2
   always_comb begin
      run  = '0;
      done = 1'b0;
      for (int i = BITS-2; i >= 0; i--) begin
         if (!done) begin
            if (data[i] == s) run = run + CW'(1);
            else              done = 1'b1;
         end
      end
   end

   assign seed = s ? (BITS'(run) - BITS'(1))
                   : ((run == CW'(BITS-1)) ? '0 : (-(BITS'(run))));

   // drop sign, regime run and terminator; zero fill
   assign shamt        = {1'b0, run} + (CW+1)'(2);
   assign shifted_data = data << shamt;
endmodule

module regime_decode_arbiter #(
   parameter int BITS  = 32,
   parameter int N_REQ = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid,
   input  logic [N_REQ*BITS-1:0]        req_data,
   output logic [N_REQ-1:0]             req_ready,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] out_id,
   output logic [BITS-1:0]              out_seed,
   output logic [BITS-1:0]              out_shifted
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic            op_valid;
   logic [ID_W-1:0] op_id;
   logic [BITS-1:0] op_data;
   logic [ID_W-1:0] rr_ptr;

   logic            out_adv;
   logic            op_load;
   logic            found;
   logic            handshake;
   logic [ID_W-1:0] win;
   logic [BITS-1:0] sel_data;
   int              scan_idx;

   logic [BITS-1:0] lk_seed;
   logic [BITS-1:0] lk_shifted;

   assign out_adv = !out_valid || out_ready;
   assign op_load = !op_valid || out_adv;

   // scan starts just after the last winner, so the last winner has lowest priority
   always_comb begin
      found    = 1'b0;
      win      = '0;
      sel_data = '0;
      scan_idx = 0;
      for (int j = 1; j <= N_REQ; j++) begin
         scan_idx = (int'(rr_ptr) + j) % N_REQ;
         if (!found && req_valid[scan_idx]) begin
            found    = 1'b1;
            win      = ID_W'(scan_idx);
            sel_data = req_data[scan_idx*BITS +: BITS];
         end
      end
   end

   assign handshake = found && op_load;
   assign req_ready = handshake ? (N_REQ'(1) << win) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_valid <= 1'b0;
         op_id    <= '0;
         op_data  <= '0;
         rr_ptr   <= ID_W'(N_REQ-1);
      end else if (op_load) begin
         op_valid <= handshake;
         if (handshake) begin
            op_data <= sel_data;
            op_id   <= win;
            rr_ptr  <= win;
         end
      end
   end

   seed_lookup #(.BITS(BITS)) u_lookup (
      .data         (op_data),
      .seed         (lk_seed),
      .shifted_data (lk_shifted)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_id      <= '0;
         out_seed    <= '0;
         out_shifted <= '0;
      end else if (out_adv) begin
         out_valid <= op_valid;
         if (op_valid) begin
            out_id      <= op_id;
            out_seed    <= lk_seed;
            out_shifted <= lk_shifted;
         end
      end
   end
endmodule

// File: tb/tb_regime_decode_arbiter.sv
// Bench for regime_decode_arbiter: scoreboard of expected decode results in acceptance order.
module tb_regime_decode_arbiter;
   localparam int BITS  = 32;
   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*BITS-1:0]   req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    out_valid;
   logic                    out_ready;
   logic [ID_W-1:0]         out_id;
   logic [BITS-1:0]         out_seed;
   logic [BITS-1:0]         out_shifted;

   regime_decode_arbiter #(.BITS(BITS), .N_REQ(N_REQ)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_id      (out_id),
      .out_seed    (out_seed),
      .out_shifted (out_shifted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [BITS-1:0] seed;
      logic [BITS-1:0] sh;
   } exp_t;

   exp_t             exp_q[$];
   int               grant_log[$];
   int               checks = 0;
   int               errors = 0;
   int               out_count = 0;
   logic [N_REQ-1:0] acc = '0;
   int               wait_cnt[N_REQ];
   exp_t             mon_e;
   exp_t             mon_g;

   function automatic void model(input logic [BITS-1:0] d,
                                 output logic [BITS-1:0] seed,
                                 output logic [BITS-1:0] sh);
      logic s;
      logic [BITS-1:0] t;
      int k;
      s = d[BITS-2];
      t = d << 1;
      k = 0;
      while (k < BITS-1 && t[BITS-1] == s) begin
         k++;
         t = t << 1;
      end
      if (s)               seed = BITS'(k - 1);
      else if (k == BITS-1) seed = '0;
      else                 seed = BITS'(-k);
      sh = (k + 2 >= BITS) ? '0 : (d << (k + 2));
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         acc = '0;
         for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
      end else begin
         acc = req_valid & req_ready;
         checks++;
         if ($countones(req_ready) > 1) begin
            errors++;
            $display("FAIL ready_onehot: req_ready=%b, required at most one bit set", req_ready);
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (acc[i]) begin
               model(req_data[i*BITS +: BITS], mon_e.seed, mon_e.sh);
               mon_e.id = ID_W'(i);
               exp_q.push_back(mon_e);
               grant_log.push_back(i);
            end
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (!req_valid[i] || acc[i]) wait_cnt[i] = 0;
            else if (|acc) begin
               wait_cnt[i]++;
               checks++;
               if (wait_cnt[i] > N_REQ-1) begin
                  errors++;
                  $display("FAIL starvation: requester %0d passed over %0d times, allowed %0d", i, wait_cnt[i], N_REQ-1);
               end
            end
         end
         if (out_valid && out_ready) begin
            out_count++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out: result id=%0d with no accepted request outstanding", out_id);
            end else begin
               mon_g = exp_q.pop_front();
               if (out_id !== mon_g.id) begin
                  errors++;
                  $display("FAIL sb_id: got %0d, expected %0d", out_id, mon_g.id);
               end
               checks++;
               if (out_seed !== mon_g.seed) begin
                  errors++;
                  $display("FAIL sb_seed: got %h, expected %h", out_seed, mon_g.seed);
               end
               checks++;
               if (out_shifted !== mon_g.sh) begin
                  errors++;
                  $display("FAIL sb_shifted: got %h, expected %h", out_shifted, mon_g.sh);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      grant_log.delete();
      rst = 1'b0;
   endtask

   task automatic wait_acc(input int i, input string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         #1;
         if (acc[i]) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: requester %0d never accepted within 50 cycles", name, i);
      end
   endtask

   // one clock: handshakes are known at the negedge, accepted requesters drop or renew after the edge
   task automatic cycle_renew(input bit renew);
      @(negedge clk);
      #1;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
         if (acc[i]) begin
            if (renew) req_data[i*BITS +: BITS] = $urandom;
            else       req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
      checks++;
      if (out_id !== '0) begin errors++; $display("FAIL reset_out_id: got %0d, expected 0", out_id); end
      checks++;
      if (out_seed !== '0) begin errors++; $display("FAIL reset_out_seed: got %h, expected 0", out_seed); end
      checks++;
      if (out_shifted !== '0) begin errors++; $display("FAIL reset_out_shifted: got %h, expected 0", out_shifted); end
   endtask

   task automatic test_first();
      do_reset();
      out_ready = 1'b1;
      req_data[0 +: BITS] = 32'h7000_0000;
      req_valid = 4'b0001;
      wait_acc(0, "first_accept");
      step();
      req_valid = '0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL first_early: out_valid=%b at accept edge, expected 0", out_valid); end
      step();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b, expected 1", out_valid); end
      checks++;
      if (out_id !== 2'd0) begin errors++; $display("FAIL first_id: got %0d, expected 0", out_id); end
      checks++;
      if (out_seed !== 32'd2) begin errors++; $display("FAIL first_seed: got %h, expected 2", out_seed); end
      step();
   endtask

   task automatic test_seeds();
      logic [BITS-1:0] din[8]  = '{32'h4000_0000, 32'h2000_0000, 32'h0000_0000, 32'h7FFF_FFFF,
                                   32'h0000_0001, 32'h8000_0000, 32'h0800_0000, 32'hFFFF_FFFF};
      logic [BITS-1:0] dexp[8] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'd30,
                                   32'hFFFF_FFE2, 32'h0000_0000, 32'hFFFF_FFFD, 32'd30};
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         req_data[BITS +: BITS] = din[k];
         req_valid = 4'b0010;
         wait_acc(1, "seed_accept");
         step();
         req_valid = '0;
         step();
         checks++;
         if (out_valid !== 1'b1 || out_id !== 2'd1) begin
            errors++;
            $display("FAIL seed_out: valid=%b id=%0d, expected valid=1 id=1", out_valid, out_id);
         end
         checks++;
         if (out_seed !== dexp[k]) begin
            errors++;
            $display("FAIL seed_value: data %h gave %h, expected %h", din[k], out_seed, dexp[k]);
         end
      end
      step();
   endtask

   task automatic test_round_robin();
      int base;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < N_REQ; i++) req_data[i*BITS +: BITS] = $urandom;
      req_valid = '1;
      base = out_count;
      for (int c = 0; c < 16; c++) cycle_renew(1'b1);
      req_valid = '0;
      repeat (3) step();
      checks++;
      if (grant_log.size() != 16) begin
         errors++;
         $display("FAIL rr_count: got %0d grants, expected 16", grant_log.size());
      end else begin
         for (int c = 0; c < 16; c++) begin
            checks++;
            if (grant_log[c] != c % N_REQ) begin
               errors++;
               $display("FAIL rr_order: grant %0d went to %0d, expected %0d", c, grant_log[c], c % N_REQ);
            end
         end
      end
      checks++;
      if (out_count - base != 16) begin errors++; $display("FAIL rr_results: got %0d results, expected 16", out_count - base); end
   endtask

   task automatic test_back_to_back_stall();
      int base;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) req_data[i*BITS +: BITS] = $urandom;
      req_valid = 4'b0111;
      base = out_count;
      for (int c = 0; c < 6; c++) cycle_renew(1'b0);
      checks++;
      if (grant_log.size() != 2) begin errors++; $display("FAIL stall_grants: got %0d accepted, expected 2", grant_log.size()); end
      checks++;
      if (req_ready !== '0) begin errors++; $display("FAIL stall_ready: got %b, expected 0000", req_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd0) begin
         errors++;
         $display("FAIL stall_out: valid=%b id=%0d, expected valid=1 id=0", out_valid, out_id);
      end
      req_data[0 +: BITS] = 32'h1234_5678;
      req_valid[0] = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) cycle_renew(1'b0);
      checks++;
      if (grant_log.size() != 4) begin
         errors++;
         $display("FAIL stall_release: got %0d grants, expected 4", grant_log.size());
      end else begin
         checks++;
         if (grant_log[2] != 2 || grant_log[3] != 0) begin
            errors++;
            $display("FAIL stall_rr_frozen: grants after release %0d,%0d, expected 2,0", grant_log[2], grant_log[3]);
         end
      end
      checks++;
      if (out_count - base != 4 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL stall_delivered: got %0d results with %0d outstanding, expected 4 and 0", out_count - base, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      req_data[2*BITS +: BITS] = 32'h3000_0000;
      req_data[3*BITS +: BITS] = 32'h6000_0000;
      req_valid = 4'b1100;
      for (int c = 0; c < 3; c++) cycle_renew(1'b0);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_setup: out_valid=%b, expected 1", out_valid); end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async: out_valid=%b, expected 0", out_valid); end
      exp_q.delete();
      grant_log.delete();
      for (int i = 0; i < N_REQ; i++) req_data[i*BITS +: BITS] = $urandom;
      req_valid = '1;
      out_ready = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) cycle_renew(1'b0);
      checks++;
      if (grant_log.size() == 0 || grant_log[0] != 0) begin
         errors++;
         $display("FAIL midrst_first: first grant %0d, expected 0", (grant_log.size() == 0) ? -1 : grant_log[0]);
      end
      req_valid = '0;
      repeat (3) step();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_drain: %0d results outstanding, expected 0", exp_q.size()); end
   endtask

   function automatic logic [BITS-1:0] gen_data();
      logic [BITS-1:0] corners[4] = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return $urandom >> $urandom_range(0, 31);
         2:       return ~($urandom >> $urandom_range(0, 31));
         default: return corners[$urandom_range(0, 3)];
      endcase
   endfunction

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         #1;
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N_REQ; i++) begin
            if (!req_valid[i] || acc[i]) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               req_data[i*BITS +: BITS] = gen_data();
            end else if ($urandom_range(0, 19) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
      end
      req_valid = '0;
      out_ready = 1'b1;
      repeat (10) step();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL random_drain: %0d results outstanding, expected 0", exp_q.size()); end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_first();
      test_seeds();
      test_round_robin();
      test_back_to_back_stall();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
